switch_conditioner: RTL and testbench
=====================================

# switch_conditioner

Conditions one raw Go Board push-button for the seven-segment counter logic. It synchronises the switch into `i_Clk` and debounces it with a counter filter. It emits a clean level, single-cycle press/release strobes, and an optional auto-repeat step strobe. One instance per switch sits between the `i_Switch_n` pins and the digit counters that drive the segment decoders in `top`.

## Interface
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable cycles required to accept a new level (20 ms at 12 MHz); legal range ≥ 1.
- `REPEAT_DELAY_CYCLES`, default 6000000: held cycles from accepted press to first repeat step (500 ms); legal range ≥ 1.
- `REPEAT_RATE_CYCLES`, default 1200000: cycles between subsequent repeat steps (100 ms); legal range ≥ 1.
- `i_Clk`  input  1  system clock, 12 MHz.
- `i_Reset`  input  1  asynchronous, active-high reset.
- `i_Switch`  input  1  raw, asynchronous, bouncing switch; 1 = pressed.
- `o_Level`  output  1  debounced switch level.
- `o_Press`  output  1  one-cycle pulse on accepted 0→1 of `o_Level`.
- `o_Release`  output  1  one-cycle pulse on accepted 1→0 of `o_Level`.
- `o_Step`  output  1  one-cycle pulse on each press and on each auto-repeat; drives counter increment.

## Operation
- Synchroniser: two flops, `sync1` → `sync2`, both reset to 0. Only `sync2` is used downstream.
- Debounce counter `deb_cnt`, width `$clog2(DEBOUNCE_CYCLES)` (minimum 1):
  - It clears on any cycle where `sync2 == o_Level`.
  - It increments on any cycle where `sync2 != o_Level`.
  - On a mismatch cycle with `deb_cnt == DEBOUNCE_CYCLES-1`, `o_Level` toggles and `deb_cnt` clears.
- Consequence: a glitch shorter than `DEBOUNCE_CYCLES` cycles at `sync2` never changes `o_Level`.
- State machine, all states reset to IDLE:
  - IDLE: `o_Level` = 0. On accepted rise → HELD, pulse `o_Press` and `o_Step`, clear `rpt_cnt`.
  - HELD: `rpt_cnt` increments. At `rpt_cnt == REPEAT_DELAY_CYCLES-1` → REPEAT, pulse `o_Step`, clear `rpt_cnt`.
  - REPEAT: `rpt_cnt` increments. At `rpt_cnt == REPEAT_RATE_CYCLES-1`, pulse `o_Step` and clear `rpt_cnt`; stay in REPEAT.
  - HELD/REPEAT: on accepted fall → IDLE, pulse `o_Release`. In that cycle `o_Step` is suppressed, even if `rpt_cnt` matches its terminal value.
- `rpt_cnt` width is `$clog2(max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES))`.
- No counter ever wraps. Every counter is compared for its terminal value and cleared at it.
- All outputs are registered; no combinational path exists from `i_Switch`.

## Timing
- Reset values: `sync1`, `sync2`, `o_Level`, `o_Press`, `o_Release`, `o_Step` = 0. `deb_cnt` and `rpt_cnt` = 0. State = IDLE.
- Press latency: let edge 0 be the first `i_Clk` rising edge that samples `i_Switch` = 1 with no bounce after it.
  - `o_Level`, `o_Press` and `o_Step` rise after edge `DEBOUNCE_CYCLES+1`.
  - `o_Press` and `o_Step` stay high for exactly one cycle.
- Release latency: symmetric. `o_Level` falls and `o_Release` pulses after edge `DEBOUNCE_CYCLES+1`, counted from the first edge sampling 0.
- First repeat `o_Step`: `REPEAT_DELAY_CYCLES` cycles after the press pulse.
- Later repeat `o_Step`s: every `REPEAT_RATE_CYCLES` cycles.
- `o_Press` and `o_Release` are never high together. `o_Release` and `o_Step` are never high together.
- Reset mid-operation: asserting `i_Reset` clears everything asynchronously, with no release pulse.
- Switch held through reset release: the switch is re-accepted as a new press `DEBOUNCE_CYCLES+2` edges after reset deasserts.

## Configuration
- `SWITCH_AUTOREPEAT_EN` defined: full behaviour with HELD/REPEAT auto-repeat as above.
- `SWITCH_AUTOREPEAT_EN` undefined:
  - `rpt_cnt`, the REPEAT state and the repeat comparators are not compiled in.
  - `o_Step` is identical to `o_Press`, one pulse per accepted press.
  - `REPEAT_*` parameters remain declared but are ignored.

## Test plan
All scenarios use parameters D=4, DELAY=20, RATE=8, a 12 MHz clock and `SWITCH_AUTOREPEAT_EN` defined unless noted.
- Clean press: `i_Switch` goes 0→1 and holds.
  - `o_Level`/`o_Press`/`o_Step` rise after edge 5; `o_Press` lasts 1 cycle.
  - Release the switch: `o_Release` pulses after edge 5 of the release, and `o_Level` = 0.
- Bounce rejection: toggle `i_Switch` high 3 cycles, low 2 cycles, repeated 4 times, then hold 0.
  - `o_Level` stays 0, and no pulse appears on any output.
- Auto-repeat: hold the switch 60 cycles after the press pulse.
  - Expect `o_Step` at press +0, +20, +28, +36, +44, +52 (6 total), `o_Press` once, and no `o_Release` until the switch is released.
- Release coincident with a repeat: arrange the accepted fall on the same cycle that `rpt_cnt` reaches 7 in REPEAT.
  - `o_Release` = 1 and `o_Step` = 0 in that cycle; state returns to IDLE.
- Reset mid-hold: assert `i_Reset` while in REPEAT with `i_Switch` still 1, then deassert.
  - All outputs are 0 immediately with no `o_Release`.
  - A new `o_Press` occurs 6 edges after deassert.
- Macro undefined: rerun the auto-repeat scenario.
  - Exactly one `o_Step`, coincident with `o_Press`.

Source files
------------

// File: rtl/switch_conditioner.sv
// ---------------------------------------------------------------------------
// switch_conditioner
//
// Conditions one raw push-button for the seven-segment counter logic:
// two-flop synchroniser, counter-based debounce filter, clean level output,
// single-cycle press/release strobes and an optional auto-repeat step strobe.
//
// Build option:
//   SWITCH_AUTOREPEAT_EN  defined   -> HELD/REPEAT auto-repeat on o_Step
//                         undefined -> o_Step is identical to o_Press
//
// Parameters:
//   DEBOUNCE_CYCLES      consecutive stable cycles to accept a new level (>=1)
//   REPEAT_DELAY_CYCLES  cycles from accepted press to first repeat step (>=1)
//   REPEAT_RATE_CYCLES   cycles between subsequent repeat steps (>=1)
//
// Ports:
//   i_Clk      system clock
//   i_Reset    asynchronous, active-high reset
//   i_Switch   raw asynchronous switch, 1 = pressed
//   o_Level    debounced level
//   o_Press    one-cycle pulse on accepted 0->1
//   o_Release  one-cycle pulse on accepted 1->0
//   o_Step     one-cycle pulse on each press and each auto-repeat
//
// States:
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | debounced level is 0, waiting for an accepted press
//   HELD    | pressed, counting the initial repeat delay
//   REPEAT  | pressed, emitting a step every REPEAT_RATE_CYCLES
// ---------------------------------------------------------------------------
module switch_conditioner #(
    parameter int DEBOUNCE_CYCLES     = 240000,
    parameter int REPEAT_DELAY_CYCLES = 6000000,
    parameter int REPEAT_RATE_CYCLES  = 1200000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Level,
    output logic o_Press,
    output logic o_Release,
    output logic o_Step
);

    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);

`ifdef SWITCH_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;

    // Repeat timing is not used in this build.
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{RPT_DELAY_LAST, RPT_RATE_LAST};
`endif

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             step_q, step_d;
    state_t           state_q, state_d;
`ifdef SWITCH_AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

    logic accept;
    logic rise;
    logic fall;

    // Synchroniser and debounce filter.
    always_comb begin
        sync1_d   = i_Switch;
        sync2_d   = sync1_q;
        level_d   = level_q;
        deb_cnt_d = '0;
        accept    = 1'b0;
        if (sync2_q != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                level_d = ~level_q;
                accept  = 1'b1;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign rise = accept & ~level_q;
    assign fall = accept &  level_q;

    // Press/release/repeat sequencing.
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        step_d    = 1'b0;
`ifdef SWITCH_AUTOREPEAT_EN
        rpt_cnt_d = rpt_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HELD;
                    press_d = 1'b1;
                    step_d  = 1'b1;
`ifdef SWITCH_AUTOREPEAT_EN
                    rpt_cnt_d = '0;
`endif
                end
            end
`ifdef SWITCH_AUTOREPEAT_EN
            ST_HELD: begin
                // Release wins over a coinciding repeat step.
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == RPT_DELAY_LAST) begin
                    state_d   = ST_REPEAT;
                    step_d    = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == RPT_RATE_LAST) begin
                    step_d    = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
`else
            ST_HELD: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
            state_q   <= ST_IDLE;
`ifdef SWITCH_AUTOREPEAT_EN
            rpt_cnt_q <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            step_q    <= step_d;
            state_q   <= state_d;
`ifdef SWITCH_AUTOREPEAT_EN
            rpt_cnt_q <= rpt_cnt_d;
`endif
        end
    end

    assign o_Level   = level_q;
    assign o_Press   = press_q;
    assign o_Release = release_q;
    assign o_Step    = step_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// ---------------------------------------------------------------------------
// tb_switch_conditioner
//
// Scoreboard bench for switch_conditioner with D=4, DELAY=20, RATE=8.
// A reference model watches the stimulus, decides from a sliding window of
// samples when a level is accepted, schedules repeat steps arithmetically and
// queues the expected pulse records; a monitor compares DUT pulses against
// the queue and checks the level every cycle.
// ---------------------------------------------------------------------------
module tb_switch_conditioner;

    localparam int D     = 4;
    localparam int DELAY = 20;
    localparam int RATE  = 8;
`ifdef SWITCH_AUTOREPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic i_Clk    = 1'b0;
    logic i_Reset  = 1'b1;
    logic i_Switch = 1'b0;
    logic o_Level, o_Press, o_Release, o_Step;

    switch_conditioner #(
        .DEBOUNCE_CYCLES    (D),
        .REPEAT_DELAY_CYCLES(DELAY),
        .REPEAT_RATE_CYCLES (RATE)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Switch (i_Switch),
        .o_Level  (o_Level),
        .o_Press  (o_Press),
        .o_Release(o_Release),
        .o_Step   (o_Step)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        int   edge_n;
        logic p;
        logic r;
        logic s;
        logic l;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // ---------------- reference model ----------------
    bit  hist[$];
    bit  m_lvl       = 1'b0;
    int  m_edge      = 0;
    int  m_next_step = -1;

    always @(posedge i_Clk) begin
        if (i_Reset) begin
            hist.delete();
            for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
            m_lvl       = 1'b0;
            m_edge      = 0;
            m_next_step = -1;
        end else begin
            bit   all_diff;
            ev_t  ev;
            m_edge++;
            hist.push_back(i_Switch);
            if (hist.size() > D + 2) void'(hist.pop_front());
            // Samples reaching the filter are two edges old; a new level needs
            // D consecutive such samples all opposite to the current level.
            all_diff = 1'b1;
            for (int i = 0; i < D; i++)
                if (hist[i] == m_lvl) all_diff = 1'b0;
            ev = '{edge_n: m_edge, p: 1'b0, r: 1'b0, s: 1'b0, l: 1'b0};
            if (all_diff && !m_lvl) begin
                m_lvl = 1'b1;
                ev.p = 1'b1;
                ev.s = 1'b1;
                m_next_step = m_edge + DELAY;
            end else if (all_diff && m_lvl) begin
                m_lvl = 1'b0;
                ev.r = 1'b1;
                m_next_step = -1;
            end else if (RPT_EN && m_lvl && m_edge == m_next_step) begin
                ev.s = 1'b1;
                m_next_step = m_edge + RATE;
            end
            ev.l = m_lvl;
            if (ev.p || ev.r || ev.s) exp_q.push_back(ev);
        end
    end

    // ---------------- monitor ----------------
    always begin
        @(posedge i_Clk);
        #1;
        if (i_Reset) begin
            n_cmp++;
            if ({o_Level, o_Press, o_Release, o_Step} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_outputs: got L/P/R/S=%b required 0000",
                         {o_Level, o_Press, o_Release, o_Step});
            end
        end else begin
            n_cmp++;
            if (o_Level !== m_lvl) begin
                n_bad++;
                $display("FAIL level @edge %0d: got %b required %b", m_edge, o_Level, m_lvl);
            end
            if (o_Press || o_Release || o_Step) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pulse @edge %0d: got P/R/S=%b%b%b required none",
                             m_edge, o_Press, o_Release, o_Step);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.edge_n != m_edge || o_Press !== e.p || o_Release !== e.r ||
                        o_Step !== e.s || o_Level !== e.l) begin
                        n_bad++;
                        $display("FAIL pulse: got edge %0d P/R/S/L=%b%b%b%b required edge %0d P/R/S/L=%b%b%b%b",
                                 m_edge, o_Press, o_Release, o_Step, o_Level,
                                 e.edge_n, e.p, e.r, e.s, e.l);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_n <= m_edge) begin
                ev_t e;
                e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_pulse @edge %0d: got none required P/R/S=%b%b%b",
                         e.edge_n, e.p, e.r, e.s);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic v, input int n);
        repeat (n) begin
            @(negedge i_Clk);
            i_Switch = v;
        end
    endtask

    task automatic reset_for(input int n);
        @(negedge i_Clk);
        i_Reset = 1'b1;
        repeat (n) @(negedge i_Clk);
        i_Reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge i_Clk);
        i_Reset = 1'b0;

        // clean press and release
        hold(1'b1, 10);
        hold(1'b0, 10);

        // bounce rejection: 3 high / 2 low, four times
        repeat (4) begin
            hold(1'b1, 3);
            hold(1'b0, 2);
        end
        hold(1'b0, 10);

        // auto-repeat: held well past several repeat steps
        hold(1'b1, D + 1 + 60);
        hold(1'b0, 12);

        // release accepted exactly when the second repeat step would fire
        hold(1'b1, DELAY + RATE);
        hold(1'b0, 12);

        // reset while repeating, switch kept pressed through reset release
        hold(1'b1, 40);
        reset_for(3);
        hold(1'b1, 20);
        hold(1'b0, 12);

        // random bouncing runs
        for (int k = 0; k < 60; k++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 12));
        end
        hold(1'b1, 45);
        hold(1'b0, 15);

        repeat (4) @(negedge i_Clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expected: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
